// File: rtl/tp_mem_wide.sv
// tp_mem_wide: two-port wide memory (one read port, one write port).
// Each word is NSEG segments of SEG_W bits. Each segment lives in its own
// DEPTH x SEG_W array, and every array uses the same addresses.
//
// Features:
//   - per-segment write mask
//   - write-first bypass when a read and a write hit the same address in
//     the same cycle
//   - optional output register stage (RD_PIPE)
//   - clear sequencer that zeroes the whole array after reset or on request
//
// Ports:
//   clk, rst      rising-edge clock; synchronous active-high reset
//   init_req      pulse that starts a clear sequence; honoured only when idle
//   init_busy     high while rst is high or while a clear is running;
//                 accesses made while it is high are ignored
//   rd_en/rd_addr read request; the result appears on rd_word with a
//                 one-cycle rd_valid strobe after 1+RD_PIPE cycles
//   wr_en/wr_addr write request
//   wr_word       write data
//   wr_mask       per-segment write enables; bit i gates segment i
module tp_mem_wide #(
  parameter int unsigned AWIDTH         = 9,
  parameter int unsigned SEG_W          = 16,
  parameter int unsigned NSEG           = 256,
  parameter int unsigned RD_PIPE        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_req,
  output logic                    init_busy,
  input  logic                    rd_en,
  input  logic [AWIDTH-1:0]       rd_addr,
  output logic [NSEG*SEG_W-1:0]   rd_word,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [AWIDTH-1:0]       wr_addr,
  input  logic [NSEG*SEG_W-1:0]   wr_word,
  input  logic [NSEG-1:0]         wr_mask
);

  localparam int unsigned DEPTH = 2**AWIDTH;
  localparam int unsigned W     = NSEG*SEG_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state;
  logic [AWIDTH-1:0]   clr_cnt;
  logic                busy;
  logic                rd_ok;
  logic                wr_ok;
  logic                clr_we;
  logic                same_addr;
  logic [W-1:0]        rd_d1;
  logic                rd_v1;

  assign busy      = rst | (state == S_CLEAR);
  assign init_busy = busy;
  assign rd_ok     = rd_en & ~busy;
  assign wr_ok     = wr_en & ~busy;
  assign clr_we    = ~rst & (state == S_CLEAR);
  assign same_addr = (rd_addr == wr_addr);

  // Clear sequencer. The terminal count is all-ones, so a clear pass takes
  // exactly DEPTH cycles and the counter never wraps into a second pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (init_req) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    logic [SEG_W-1:0] mem [DEPTH];
    logic [SEG_W-1:0] seg_q;
    logic [SEG_W-1:0] wr_seg;
    logic             seg_we;

    assign wr_seg = wr_word[g*SEG_W +: SEG_W];
    assign seg_we = wr_ok & wr_mask[g];

    // clr_we and wr_ok are mutually exclusive because wr_ok requires !busy.
    always_ff @(posedge clk) begin
      if (clr_we)      mem[clr_cnt] <= '0;
      else if (seg_we) mem[wr_addr] <= wr_seg;
    end

    // Write-first: a masked segment being written to the read address
    // returns the new data; all other segments return the stored contents.
    always_ff @(posedge clk) begin
      if (rst)        seg_q <= '0;
      else if (rd_ok) seg_q <= (seg_we && same_addr) ? wr_seg : mem[rd_addr];
    end

    assign rd_d1[g*SEG_W +: SEG_W] = seg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_v1 <= 1'b0;
    else     rd_v1 <= rd_ok;
  end

  if (RD_PIPE == 0) begin : g_nopipe
    assign rd_word  = rd_d1;
    assign rd_valid = rd_v1;
  end else begin : g_pipe
    logic [W-1:0] rd_d2;
    logic         rd_v2;

    // The stage only loads on a valid beat, so rd_word holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_d2 <= '0;
        rd_v2 <= 1'b0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_d2 <= rd_d1;
      end
    end

    assign rd_word  = rd_d2;
    assign rd_valid = rd_v2;
  end

endmodule

// File: doc/tp_mem_wide.md
# tp_mem_wide

Parametrised two-port wide memory for the MVU user-memory path: one read port and one write port, words of NSEG×SEG_W bits. Adds what the fixed-size version lacks: per-segment write mask, write-first bypass on same-address read/write, optional output pipeline stage with a read-valid strobe, and a hardware clear sequencer that zeroes the whole array after reset or on request. Drop-in replacement for the fixed 512×4096 instance when NSEG=256, SEG_W=16, AWIDTH=9, RD_PIPE=0 and mask is all-ones.

## Interface
- AWIDTH, 9: address width; depth DEPTH = 2**AWIDTH
- SEG_W, 16: segment width in bits
- NSEG, 256: segments per word; word width W = NSEG*SEG_W
- RD_PIPE, 0: extra output register stages after the array read (0 or 1)
- CLEAR_ON_RESET, 1: 1 = run clear sequence after reset; 0 = idle after reset
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- init_req  in  1  pulse: start clear sequence (honoured only in IDLE)
- init_busy  out  1  high while clear sequence runs or rst is high
- rd_en  in  1  read request
- rd_addr  in  AWIDTH  read address
- rd_word  out  W  read data, held between valid reads
- rd_valid  out  1  one-cycle strobe: rd_word carries data for an accepted read
- wr_en  in  1  write request
- wr_addr  in  AWIDTH  write address
- wr_word  in  W  write data; segment i = wr_word[SEG_W*i +: SEG_W]
- wr_mask  in  NSEG  per-segment write enable; bit i gates segment i

## Operation
- Storage: NSEG independent DEPTH×SEG_W arrays, one per segment, all sharing addresses.
- Write: wr_en & !init_busy -> each segment i with wr_mask[i]=1 stored at wr_addr; others unchanged.
- Read: rd_en & !init_busy accepted; array output registered, then RD_PIPE further registers.
- Same-cycle rd_en & wr_en, rd_addr==wr_addr: write-first per segment — masked segments return wr_word segment, unmasked return old contents.
- rd_en or wr_en while init_busy: ignored; no rd_valid, no array change.
- Clear FSM, states IDLE and CLEAR:
  - rst high: state CLEAR if CLEAR_ON_RESET else IDLE; counter = 0; no array writes during rst.
  - CLEAR: write zero to all segments at counter, counter++; at counter = DEPTH-1 write last address then -> IDLE.
  - IDLE: init_req -> CLEAR, counter = 0. init_req in CLEAR ignored (no restart).
  - rst asserted mid-clear: sequence restarts from address 0 after rst falls.
- init_busy = rst | (state==CLEAR).
- Counter is AWIDTH+0 bits; terminal detect on all-ones, no wrap into a second pass.

## Timing
- Reset values: rd_word = 0, rd_valid = 0, init_busy = 1 while rst high; after rst falls init_busy = 1 (CLEAR_ON_RESET=1) or 0.
- Clear duration: exactly DEPTH cycles; init_busy falls on the edge after the write of address DEPTH-1; first accepted access is the cycle init_busy reads 0.
- Read latency: 1+RD_PIPE cycles from accepted rd_en edge to rd_valid=1 with data.
- Back-to-back reads every cycle supported; rd_valid follows rd_en pattern delayed by latency.
- Write visible to a read of the same address issued the same cycle (bypass) and any later cycle.
- rd_word holds last value when rd_valid=0; rst clears it and all pipeline valids.
- init_req and rd/wr in the same IDLE cycle: access is accepted, clear starts next cycle.

## Test plan
- Reset, CLEAR_ON_RESET=1, DEPTH=512 -> init_busy high 512 cycles after rst falls; then reads of addr 0, 255, 511 return 0 with rd_valid after 1 cycle (RD_PIPE=0) and 2 cycles (RD_PIPE=1).
- Write 0xA5A5… full mask at addr 7, then wr_mask with only segment 0 set, data 0x1234 in seg 0 -> read addr 7 returns seg0=0x1234, segs 1..255=0xA5A5.
- Same-cycle write (mask = even segments, data 0xFFFF) and read at addr 3 holding 0x0000 -> rd_word even segs 0xFFFF, odd segs 0x0000.
- Accesses during clear: wr_en at addr 10 with 0xBEEF mid-clear -> ignored, later read returns 0; rd_en mid-clear -> no rd_valid.
- rst pulse at counter 200 of a clear -> init_busy stays high, full 512-cycle clear reruns; data written before reset reads 0.
- init_req while IDLE after writes to addr 0 and 511 -> 512-cycle busy, both read 0; second init_req mid-clear does not extend busy.
